// File: rtl/rv32i_types_pkg.sv
// Shared writeback types: requester count, requester indices and the request bundle.
package rv32i_types_pkg;

   localparam int NUM_REQ   = 4;
   localparam int WB_WORD_W = 32;
   localparam int RD_W      = 5;

   typedef enum logic [1:0] {
      WB_AU  = 2'd0,
      WB_MUL = 2'd1,
      WB_DIV = 2'd2,
      WB_LSU = 2'd3
   } wb_src_e;

   typedef struct packed {
      logic                 wen;
      logic [RD_W-1:0]      rd;
      logic [WB_WORD_W-1:0] wdata;
   } wb_req_t;

   // Round-robin pointer advance: index after idx, wrapping at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer, wrapping around.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt
);

   int   w_idx;
   logic w_hit;

   // Scan the requests in rotated order and grant only the first one found.
   always_comb begin
      o_gnt = '0;
      w_hit = 1'b0;
      w_idx = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         if (!w_hit && i_req[w_idx[PW-1:0]]) begin
            o_gnt[w_idx[PW-1:0]] = 1'b1;
            w_hit                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one functional-unit result per cycle, registers it
// onto the register-file write port and counts contended cycles.
module writeback_arbiter
   import rv32i_types_pkg::RD_W;
   import rv32i_types_pkg::wrap_inc;
#(
   parameter  int NUM_REQ = rv32i_types_pkg::NUM_REQ,
   parameter  int WORD_W  = rv32i_types_pkg::WB_WORD_W,
   localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           flush,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_wen,
   input  logic [NUM_REQ-1:0][RD_W-1:0]   req_rd,
   input  logic [NUM_REQ-1:0][WORD_W-1:0] req_wdata,
   output logic                           rf_wen,
   output logic [RD_W-1:0]                rf_rd,
   output logic [WORD_W-1:0]              rf_wdata,
   output logic                           retire_valid,
   output logic [SRC_W-1:0]               retire_src,
   output logic [31:0]                    conflict_cnt
);

   logic [SRC_W-1:0]   r_rr_ptr;
   logic               r_rf_wen;
   logic [RD_W-1:0]    r_rf_rd;
   logic [WORD_W-1:0]  r_rf_wdata;
   logic               r_retire_valid;
   logic [SRC_W-1:0]   r_retire_src;
   logic [31:0]        r_conflict_cnt;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_gnt;
   logic               w_grant;
   logic [SRC_W-1:0]   w_gidx;
   logic               w_contended;

   // A flush squashes every request before it reaches the arbiter.
   assign w_req = flush ? '0 : req_valid;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .i_req (w_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt)
   );

   // Ready is masked by reset so nothing can be consumed while the block is held.
   assign req_ready   = nRST ? w_gnt : '0;
   assign w_grant     = |w_gnt;
   assign w_contended = !flush && ($countones(req_valid) > 1);

   // One-hot grant to index.
   always_comb begin
      w_gidx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_gnt[k[SRC_W-1:0]]) begin
            w_gidx = k[SRC_W-1:0];
         end
      end
   end

   // Output register, round-robin pointer and saturating contention counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rr_ptr       <= '0;
         r_rf_wen       <= 1'b0;
         r_rf_rd        <= '0;
         r_rf_wdata     <= '0;
         r_retire_valid <= 1'b0;
         r_retire_src   <= '0;
         r_conflict_cnt <= '0;
      end else begin
         // x0 is hard-wired zero: such results retire without a register write.
         r_rf_wen       <= w_grant && req_wen[w_gidx] && (req_rd[w_gidx] != '0);
         r_retire_valid <= w_grant;
         if (w_grant) begin
            r_rf_rd      <= req_rd[w_gidx];
            r_rf_wdata   <= req_wdata[w_gidx];
            r_retire_src <= w_gidx;
            r_rr_ptr     <= SRC_W'(wrap_inc(32'(w_gidx), NUM_REQ));
         end
         if (w_contended && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
         end
      end
   end

   assign rf_wen       = r_rf_wen;
   assign rf_rd        = r_rf_rd;
   assign rf_wdata     = r_rf_wdata;
   assign retire_valid = r_retire_valid;
   assign retire_src   = r_retire_src;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: the stimulus side models requesters
// and the arbitration rules, the monitor side checks every registered output.
module tb_writeback_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              flush;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_wen;
   logic [N-1:0][4:0] req_rd;
   logic [N-1:0][W-1:0] req_wdata;
   logic              rf_wen;
   logic [4:0]        rf_rd;
   logic [W-1:0]      rf_wdata;
   logic              retire_valid;
   logic [1:0]        retire_src;
   logic [31:0]       conflict_cnt;

   always #5 CLK = ~CLK;

   writeback_arbiter #(.NUM_REQ(N), .WORD_W(W)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_rd       (req_rd),
      .req_wdata    (req_wdata),
      .rf_wen       (rf_wen),
      .rf_rd        (rf_rd),
      .rf_wdata     (rf_wdata),
      .retire_valid (retire_valid),
      .retire_src   (retire_src),
      .conflict_cnt (conflict_cnt)
   );

   typedef struct {
      int          src;
      bit          wen;
      logic [4:0]  rd;
      logic [31:0] wd;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_err    = 0;

   // Requester model: each unit holds its transaction until granted.
   bit          pend_v  [N];
   bit          pend_wen[N];
   logic [4:0]  pend_rd [N];
   logic [31:0] pend_wd [N];

   int          m_ptr;
   logic [31:0] exp_cnt;
   logic [4:0]  last_rd;
   logic [31:0] last_wd;
   bit          mon_en;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      exp_cnt = 32'd0;
      last_rd = 5'd0;
      last_wd = 32'd0;
      sb_q.delete();
      for (int i = 0; i < N; i++) begin
         pend_v[i]   = 1'b0;
         pend_wen[i] = 1'b0;
         pend_rd[i]  = 5'd0;
         pend_wd[i]  = 32'd0;
      end
   endtask

   task automatic set_req(input int i, input bit wen, input logic [4:0] rd, input logic [31:0] wd);
      pend_v[i]   = 1'b1;
      pend_wen[i] = wen;
      pend_rd[i]  = rd;
      pend_wd[i]  = wd;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rf_wen"},       rf_wen,       0);
      check({tag, "_rf_rd"},        rf_rd,        0);
      check({tag, "_rf_wdata"},     rf_wdata,     0);
      check({tag, "_retire_valid"}, retire_valid, 0);
      check({tag, "_retire_src"},   retire_src,   0);
      check({tag, "_conflict_cnt"}, conflict_cnt, 0);
      check({tag, "_req_ready"},    req_ready,    0);
   endtask

   // One arbitration cycle: drive requesters, predict the grant from the
   // round-robin rule, check ready and queue the expected writeback.
   task automatic cycle(input bit fl);
      int         g;
      int         nv;
      int         idx;
      logic [3:0] exp_rdy;
      exp_t       e;
      @(negedge CLK);
      flush = fl;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pend_v[i];
         req_wen[i]   = pend_wen[i];
         req_rd[i]    = pend_rd[i];
         req_wdata[i] = pend_wd[i];
      end
      #1;
      g  = -1;
      nv = 0;
      for (int i = 0; i < N; i++) begin
         if (pend_v[i]) nv++;
      end
      if (!fl) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && pend_v[idx]) g = idx;
         end
      end
      exp_rdy = 4'd0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (!fl && nv >= 2 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (g >= 0) begin
         e.src = g;
         e.wen = pend_wen[g] && (pend_rd[g] != 5'd0);
         e.rd  = pend_rd[g];
         e.wd  = pend_wd[g];
         sb_q.push_back(e);
         pend_v[g] = 1'b0;
         m_ptr     = (g + 1) % N;
      end
   endtask

   // Monitor: after each rising edge compare registered outputs with the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (mon_en) begin
            if (retire_valid) begin
               if (sb_q.size() == 0) begin
                  check("spurious_retire", retire_valid, 0);
               end else begin
                  e = sb_q.pop_front();
                  check("retire_src", retire_src, e.src);
                  check("rf_wen",     rf_wen,     e.wen);
                  check("rf_rd",      rf_rd,      e.rd);
                  check("rf_wdata",   rf_wdata,   e.wd);
                  last_rd = e.rd;
                  last_wd = e.wd;
               end
            end else begin
               check("idle_rf_wen",   rf_wen,   0);
               check("hold_rf_rd",    rf_rd,    last_rd);
               check("hold_rf_wdata", rf_wdata, last_wd);
            end
            check("conflict_cnt", conflict_cnt, exp_cnt);
         end
      end
   end

   initial begin
      mon_en    = 1'b0;
      nRST      = 1'b0;
      flush     = 1'b0;
      req_valid = '1;
      req_wen   = '1;
      req_rd    = '1;
      req_wdata = '1;
      model_reset();
      #2;
      check_reset("por");

      @(negedge CLK);
      nRST      = 1'b1;
      req_valid = '0;
      mon_en    = 1'b1;

      // Reset between a grant and its output cycle discards the pending write.
      set_req(0, 1'b1, 5'd7, 32'h1234_5678);
      cycle(1'b0);
      #1;
      nRST   = 1'b0;
      mon_en = 1'b0;
      #1;
      check_reset("midrst");
      model_reset();
      @(negedge CLK);
      nRST      = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      mon_en    = 1'b1;
      cycle(1'b0);

      // Full contention from reset: grants 0,1,2,3, three contended cycles.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), $urandom);
      repeat (4) cycle(1'b0);
      @(posedge CLK);
      #2;
      check("contention_cnt", conflict_cnt, 32'd3);

      // Single AU write, then pointer at 1 favours MUL over AU.
      set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      cycle(1'b0);
      set_req(0, 1'b1, 5'd6, 32'h0000_0001);
      set_req(1, 1'b1, 5'd7, 32'h0000_0002);
      cycle(1'b0);
      cycle(1'b0);

      // LSU write to x0 retires without a register write.
      set_req(3, 1'b1, 5'd0, 32'h0000_CAFE);
      cycle(1'b0);

      // Flush with MUL and DIV pending, then MUL first.
      set_req(1, 1'b1, 5'd11, 32'h1111_0000);
      set_req(2, 1'b1, 5'd12, 32'h2222_0000);
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b0);

      // Randomised traffic with occasional flushes.
      repeat (1500) begin
         for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom);
            end
         end
         cycle($urandom_range(0, 7) == 0);
      end
      repeat (N) cycle(1'b0);
      cycle(1'b0);

      // Saturation: preload near the top, then three contended cycles.
      force dut.r_conflict_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_conflict_cnt;
      exp_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), $urandom);
      repeat (4) cycle(1'b0);
      @(posedge CLK);
      #2;
      check("sat_cnt", conflict_cnt, 32'hFFFF_FFFF);

      repeat (2) cycle(1'b0);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of functional-unit requesters (index 0 = arithmetic unit, 1 = multiply, 2 = divide, 3 = load-store).
REQ-002 Parameter WORD_W, default 32, SHALL set the write-data width.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-low reset:
- CLK  in  1  sole clock; all state updates on the rising edge
- nRST  in  1  asynchronous, active-low reset
REQ-004 Remaining ports SHALL be:
- flush  in  1  squash: no grant this cycle
- req_valid  in  NUM_REQ  per-unit result valid
- req_ready  out  NUM_REQ  per-unit grant; combinational, one-hot or zero
- req_wen  in  NUM_REQ  per-unit register-write intent
- req_rd  in  NUM_REQ x 5  per-unit destination register
- req_wdata  in  NUM_REQ x WORD_W  per-unit result (arithmetic unit's wdata_au on index 0)
- rf_wen  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  WORD_W  register-file write data
- retire_valid  out  1  one instruction retired (a write is not required)
- retire_src  out  clog2(NUM_REQ)  index of the retiring unit
- conflict_cnt  out  32  saturating count of contended cycles

Function
REQ-005 Handshake: a transfer SHALL occur on requester i when req_valid[i] && req_ready[i]; a requester SHALL hold valid, rd, wen and wdata stable until granted.
REQ-006 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be all-zero when flush=1 or no req_valid is set.
REQ-007 Grant SHALL be round-robin: the lowest valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-008 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-009 The output stage SHALL be registered with latency one cycle: the grant in cycle N appears on rf_* and retire_* in cycle N+1.
REQ-010 On a grant, rf_wen SHALL be req_wen[g] && (req_rd[g] != 0); writes to x0 SHALL retire with rf_wen=0.
REQ-011 rf_rd and rf_wdata SHALL be captured from the granted requester; without a grant they SHALL hold their prior values while rf_wen=0 and retire_valid=0.
REQ-012 flush=1 SHALL suppress the grant in that cycle, leave rr_ptr unchanged and force rf_wen=0 and retire_valid=0 in the next cycle; the output register already loaded in the flush cycle SHALL still be presented.
REQ-013 conflict_cnt SHALL increment in each cycle in which flush=0 and two or more req_valid bits are set, and SHALL saturate at 0xFFFF_FFFF.
REQ-014 Every valid requester SHALL be granted within NUM_REQ cycles of asserting valid while flush stays 0 (starvation freedom).

Reset
REQ-015 When nRST is low, rr_ptr, rf_wen, rf_rd, rf_wdata, retire_valid, retire_src and conflict_cnt SHALL be 0 immediately, independent of CLK.
REQ-016 req_ready SHALL be all-zero while nRST is low.
REQ-017 A reset asserted mid-stream SHALL discard the output register contents; no write SHALL appear after deassertion until a new grant occurs.

Structure
REQ-018 NUM_REQ, the requester-index enum (WB_AU, WB_MUL, WB_DIV, WB_LSU) and a packed wb_req_t (wen, rd, wdata) SHALL live in rv32i_types_pkg.
REQ-019 The grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant); the remaining logic (output register, pointer and counter) SHALL be in writeback_arbiter.

Verification
REQ-020 Single requester: AU valid, rd=5, wdata=0xDEADBEEF, wen=1 -> req_ready[0]=1 the same cycle; next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF, retire_src=0; rr_ptr=1.
REQ-021 Full contention: all 4 valid continuously from reset, each dropping valid after its grant -> grants in order 0,1,2,3 on consecutive cycles; conflict_cnt=3.
REQ-022 x0 write: LSU valid, rd=0, wen=1 -> retire_valid=1, retire_src=3, rf_wen=0.
REQ-023 Flush: MUL and DIV valid with flush=1 for one cycle -> req_ready=0 that cycle, rf_wen=0 and retire_valid=0 next cycle, conflict_cnt unchanged; after flush drops, MUL (index 1) is granted first when rr_ptr=0.
REQ-024 Reset mid-operation: nRST pulled low between a grant and its output cycle -> all outputs 0 immediately; after release with no valid input, rf_wen stays 0.
REQ-025 Saturation: conflict_cnt forced to 0xFFFF_FFFE, then 3 contended cycles -> conflict_cnt = 0xFFFF_FFFF.
